// File: rtl/corr_pkg.sv
//------------------------------------------------------------------------------
// Module   : corr_pkg
// Purpose  : Shared types and constants for the correlation sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package corr_pkg;

    localparam int c_cw      = 16;
    localparam int c_samples = 128;
    localparam int c_pattern = 32;

    // Starting point for the peak search so the first real window always wins
    localparam logic signed [c_cw-1:0] c_cw_min = {1'b1, {(c_cw-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/control_correlacion_if.sv
//------------------------------------------------------------------------------
// Module   : control_correlacion_if
// Purpose  : Sample stream plus correlator strobe/result bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface control_correlacion_if
    import corr_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = c_cw
);

    logic                 s_valid;
    logic                 s_ready;
    logic [W-1:0]         s_data;
    logic [W-1:0]         corr_data;
    logic                 corr_shift;
    logic                 corr_p;
    logic                 corr_en;
    logic                 corr_valid;
    logic signed [CW-1:0] corr_value;

    // The sequencer masters both the sample stream and the correlator
    modport master (
        input  s_valid,
        input  s_data,
        input  corr_valid,
        input  corr_value,
        output s_ready,
        output corr_data,
        output corr_shift,
        output corr_p,
        output corr_en
    );

    modport slave (
        output s_valid,
        output s_data,
        output corr_valid,
        output corr_value,
        input  s_ready,
        input  corr_data,
        input  corr_shift,
        input  corr_p,
        input  corr_en
    );

endinterface

`default_nettype wire

// File: rtl/peak_tracker.sv
//------------------------------------------------------------------------------
// Module   : peak_tracker
// Purpose  : Holds the running signed maximum and the index where it occurred.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module peak_tracker
    import corr_pkg::*;
#(
    parameter int                      CW        = c_cw,
    parameter int                      IW        = 7,
    parameter logic signed [CW-1:0]    MIN_VALUE = c_cw_min
)(
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 init,
    input  wire logic                 update,
    input  wire logic signed [CW-1:0] value,
    input  wire logic [IW-1:0]        index,
    output logic signed [CW-1:0]      peak_value,
    output logic [IW-1:0]             peak_index
);

    // Strict greater-than keeps the earliest index on ties
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_value <= '0;
            peak_index <= '0;
        end else if (init) begin
            peak_value <= MIN_VALUE;
            peak_index <= '0;
        end else if (update && (value > peak_value)) begin
            peak_value <= value;
            peak_index <= index;
        end
    end

endmodule

`default_nettype wire

// File: rtl/control_correlacion.sv
//------------------------------------------------------------------------------
// Module   : control_correlacion
// Purpose  : Feeds samples into the correlator window, strobes each full
//            window and tracks the peak correlation over one run.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_correlacion
    import corr_pkg::*;
#(
    parameter int SAMPLES = c_samples,
    parameter int PATTERN = c_pattern,
    parameter int W       = 32,
    parameter int CW      = c_cw,
    parameter int TMO     = 16,
    parameter int IW      = $clog2(SAMPLES)
)(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic signed [CW-1:0]  peak_value,
    output logic [IW-1:0]         peak_index,
    control_correlacion_if.master bus
);

    localparam int c_cntw = $clog2(SAMPLES + 1);
    localparam int c_tw   = (TMO > 1) ? $clog2(TMO) : 1;

    localparam logic [c_cntw-1:0]      c_fill_last  = c_cntw'(PATTERN - 1);
    localparam logic [c_cntw-1:0]      c_count_full = c_cntw'(SAMPLES);
    localparam logic [c_tw-1:0]        c_tmo_last   = c_tw'(TMO - 1);
    localparam logic signed [CW-1:0]   c_peak_init  = {1'b1, {(CW-1){1'b0}}};

    state_t              r_state;
    state_t              w_next;
    logic [c_cntw-1:0]   r_count;
    logic [c_tw-1:0]     r_timer;
    logic                r_err;

    logic                w_busy;
    logic                w_done;
    logic                w_ready;
    logic                w_shift;
    logic                w_strobe;
    logic                w_init;
    logic                w_update;
    logic                w_timeout;
    logic [IW-1:0]       w_index;
    logic [W-1:0]        w_sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_busy    = 1'b1;
        w_done    = 1'b0;
        w_ready   = 1'b0;
        w_strobe  = 1'b0;
        w_init    = 1'b0;
        w_update  = 1'b0;
        w_timeout = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_init = 1'b1;
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_ready = 1'b1;
                // Count is compared before it increments: the PATTERN-th
                // sample completes the first window
                if (bus.s_valid && (r_count >= c_fill_last)) begin
                    w_next = ST_STROBE;
                end
            end
            ST_STROBE: begin
                w_strobe = 1'b1;
                w_next   = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.corr_valid) begin
                    w_update = 1'b1;
                    w_next   = (r_count == c_count_full) ? ST_DONE : ST_LOAD;
                end else if (r_timer == c_tmo_last) begin
                    w_timeout = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_shift = w_ready & bus.s_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_init) begin
                r_count <= '0;
            end else if (w_shift) begin
                r_count <= r_count + c_cntw'(1);
            end

            if (w_strobe) begin
                r_timer <= '0;
            end else if (r_state == ST_WAIT) begin
                r_timer <= r_timer + c_tw'(1);
            end

            if (w_init) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Count already includes the sample that closed this window
    assign w_index = IW'(r_count - c_cntw'(1));

    peak_tracker #(
        .CW        (CW),
        .IW        (IW),
        .MIN_VALUE (c_peak_init)
    ) u_peak_tracker (
        .clk        (clk),
        .rst        (rst),
        .init       (w_init),
        .update     (w_update),
        .value      (bus.corr_value),
        .index      (w_index),
        .peak_value (peak_value),
        .peak_index (peak_index)
    );

    assign w_sample       = bus.s_data;
    assign bus.corr_data  = w_sample;
    assign bus.s_ready    = w_ready;
    assign bus.corr_shift = w_shift;
    assign bus.corr_p     = w_strobe;
    assign bus.corr_en    = w_busy;

    assign busy = w_busy;
    assign done = w_done;
    assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_control_correlacion.sv
//------------------------------------------------------------------------------
// Module   : tb_control_correlacion
// Purpose  : Directed bench for control_correlacion with a latency-3 correlator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_control_correlacion;

    localparam int SAMPLES = 8;
    localparam int PATTERN = 4;
    localparam int W       = 32;
    localparam int CW      = 16;
    localparam int TMO     = 16;
    localparam int IW      = 3;
    localparam int LAT     = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic signed [CW-1:0] peak_value;
    logic [IW-1:0]        peak_index;

    control_correlacion_if #(.W(W), .CW(CW)) bus ();

    control_correlacion #(
        .SAMPLES (SAMPLES),
        .PATTERN (PATTERN),
        .W       (W),
        .CW      (CW),
        .TMO     (TMO),
        .IW      (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .peak_value (peak_value),
        .peak_index (peak_index),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Environment controls and monitor counters
    bit                   src_on   = 1'b0;
    int                   src_duty = 100;
    logic [W-1:0]         src_data = '0;
    bit                   corr_on  = 1'b1;
    int                   corr_idx = 0;
    logic signed [CW-1:0] corr_tbl [0:7];
    int shift_cnt = 0, strobe_cnt = 0, done_cnt = 0, fill_viol = 0;
    int data_err = 0, en_err = 0, wait_cyc = 0;

    // Sample source: data advances only when the DUT accepts it
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        forever begin
            @(negedge clk);
            if (src_on && (src_duty >= 100 || $urandom_range(0, 99) < 32'(src_duty))) begin
                bus.s_valid = 1'b1;
                bus.s_data  = src_data;
                if (bus.s_ready) src_data = src_data + 1;
            end else begin
                bus.s_valid = 1'b0;
            end
        end
    end

    // Correlator model: result LAT edges after the strobe edge
    initial begin : corr_model
        logic signed [CW-1:0] resp;
        bus.corr_valid = 1'b0;
        bus.corr_value = '0;
        forever begin
            @(negedge clk);
            bus.corr_valid = 1'b0;
            if (corr_on && bus.corr_p) begin
                resp = (corr_idx < 8) ? corr_tbl[corr_idx] : '0;
                corr_idx++;
                repeat (LAT) @(negedge clk);
                bus.corr_valid = 1'b1;
                bus.corr_value = resp;
            end
        end
    end

    // Monitor samples one time unit before each rising edge
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (bus.corr_shift) begin
                shift_cnt++;
                if (bus.corr_data !== bus.s_data) data_err++;
            end
            if (bus.corr_p) begin
                strobe_cnt++;
                if (shift_cnt < PATTERN) fill_viol++;
            end
            if (done) done_cnt++;
            if (busy && !bus.s_ready && !bus.corr_p && !done) wait_cyc++;
            if (bus.corr_en !== busy) en_err++;
        end
    end

    task automatic clear_counts();
        shift_cnt = 0; strobe_cnt = 0; done_cnt = 0; fill_viol = 0;
        data_err = 0; en_err = 0; wait_cyc = 0; corr_idx = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == 0) begin failures++; $display("FAIL %s_done_timeout got=no_done exp=done within %0d cycles", name, budget); end
    endtask

    task automatic load_tie_table();
        corr_tbl = '{16'sd5, -16'sd3, 16'sd9, 16'sd9, 16'sd2, 16'sd0, 16'sd0, 16'sd0};
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b exp=0", bus.s_ready); end
        checks++; if (bus.corr_p !== 1'b0) begin failures++; $display("FAIL rst_corr_p got=%b exp=0", bus.corr_p); end
        checks++; if (bus.corr_shift !== 1'b0) begin failures++; $display("FAIL rst_corr_shift got=%b exp=0", bus.corr_shift); end
        checks++; if (bus.corr_en !== 1'b0) begin failures++; $display("FAIL rst_corr_en got=%b exp=0", bus.corr_en); end
        checks++; if (peak_value !== 16'sd0) begin failures++; $display("FAIL rst_peak_value got=%0d exp=0", peak_value); end
        checks++; if (peak_index !== 3'd0) begin failures++; $display("FAIL rst_peak_index got=%0d exp=0", peak_index); end
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_start_ignored busy got=%b exp=0", busy); end
    endtask

    task automatic test_peak_tie();
        load_tie_table();
        clear_counts();
        src_duty = 100; src_on = 1'b1; corr_on = 1'b1;
        pulse_start();
        wait_done("tie", 400);
        src_on = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tie_busy_after_done got=%b exp=0", busy); end
        checks++; if (peak_value !== 16'sd9) begin failures++; $display("FAIL tie_peak_value got=%0d exp=9", peak_value); end
        checks++; if (peak_index !== 3'd5) begin failures++; $display("FAIL tie_peak_index got=%0d exp=5", peak_index); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL tie_err got=%b exp=0", err); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL tie_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (shift_cnt != SAMPLES) begin failures++; $display("FAIL tie_shifts got=%0d exp=%0d", shift_cnt, SAMPLES); end
        checks++; if (strobe_cnt != SAMPLES - PATTERN + 1) begin failures++; $display("FAIL tie_strobes got=%0d exp=%0d", strobe_cnt, SAMPLES - PATTERN + 1); end
        checks++; if (fill_viol != 0) begin failures++; $display("FAIL tie_fill_strobe got=%0d exp=0", fill_viol); end
        checks++; if (data_err != 0) begin failures++; $display("FAIL tie_corr_data got=%0d mismatches exp=0", data_err); end
        checks++; if (en_err != 0) begin failures++; $display("FAIL tie_corr_en got=%0d mismatches exp=0", en_err); end
    endtask

    task automatic test_all_negative();
        corr_tbl = '{-16'sd7, -16'sd2, -16'sd9, -16'sd2, -16'sd5, 16'sd0, 16'sd0, 16'sd0};
        clear_counts();
        src_duty = 100; src_on = 1'b1; corr_on = 1'b1;
        pulse_start();
        wait_done("neg", 400);
        src_on = 1'b0;
        checks++; if (peak_value !== -16'sd2) begin failures++; $display("FAIL neg_peak_value got=%0d exp=-2", peak_value); end
        checks++; if (peak_index !== 3'd4) begin failures++; $display("FAIL neg_peak_index got=%0d exp=4", peak_index); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL neg_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        load_tie_table();
        clear_counts();
        src_duty = 30; src_on = 1'b1; corr_on = 1'b1;
        pulse_start();
        while (shift_cnt < 5 && n < 600) begin
            @(negedge clk);
            n++;
        end
        pulse_start();
        wait_done("bp", 3000);
        src_on = 1'b0;
        checks++; if (peak_value !== 16'sd9) begin failures++; $display("FAIL bp_peak_value got=%0d exp=9", peak_value); end
        checks++; if (peak_index !== 3'd5) begin failures++; $display("FAIL bp_peak_index got=%0d exp=5", peak_index); end
        checks++; if (shift_cnt != SAMPLES) begin failures++; $display("FAIL bp_shifts got=%0d exp=%0d", shift_cnt, SAMPLES); end
        checks++; if (strobe_cnt != SAMPLES - PATTERN + 1) begin failures++; $display("FAIL bp_strobes got=%0d exp=%0d", strobe_cnt, SAMPLES - PATTERN + 1); end
        checks++; if (fill_viol != 0) begin failures++; $display("FAIL bp_fill_strobe got=%0d exp=0", fill_viol); end
        checks++; if (data_err != 0) begin failures++; $display("FAIL bp_corr_data got=%0d mismatches exp=0", data_err); end
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_start_ignored busy got=%b exp=0", busy); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_timeout();
        clear_counts();
        src_duty = 100; src_on = 1'b1; corr_on = 1'b0;
        pulse_start();
        wait_done("tmo", 300);
        src_on = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_busy_after_done got=%b exp=0", busy); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", err); end
        checks++; if (wait_cyc != TMO) begin failures++; $display("FAIL tmo_wait_cycles got=%0d exp=%0d", wait_cyc, TMO); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL tmo_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (strobe_cnt != 1) begin failures++; $display("FAIL tmo_strobes got=%0d exp=1", strobe_cnt); end
        checks++; if (peak_value !== 16'sh8000) begin failures++; $display("FAIL tmo_peak_value got=%0d exp=-32768", peak_value); end
        checks++; if (peak_index !== 3'd0) begin failures++; $display("FAIL tmo_peak_index got=%0d exp=0", peak_index); end
        corr_on = 1'b1;
    endtask

    task automatic test_reset_midrun();
        int n = 0;
        load_tie_table();
        clear_counts();
        src_duty = 100; src_on = 1'b1; corr_on = 1'b1;
        pulse_start();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL mid_err_cleared_by_start got=%b exp=0", err); end
        while (strobe_cnt < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (LAT + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy_after_rst got=%b exp=0", busy); end
        checks++; if (peak_value !== 16'sd0) begin failures++; $display("FAIL mid_peak_value_after_rst got=%0d exp=0", peak_value); end
        checks++; if (peak_index !== 3'd0) begin failures++; $display("FAIL mid_peak_index_after_rst got=%0d exp=0", peak_index); end
        repeat (8) @(negedge clk);
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL mid_aborted_done got=%0d exp=0", done_cnt); end
        clear_counts();
        pulse_start();
        wait_done("mid", 400);
        src_on = 1'b0;
        checks++; if (peak_value !== 16'sd9) begin failures++; $display("FAIL mid_peak_value got=%0d exp=9", peak_value); end
        checks++; if (peak_index !== 3'd5) begin failures++; $display("FAIL mid_peak_index got=%0d exp=5", peak_index); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL mid_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_peak_tie();
        test_all_negative();
        test_backpressure();
        test_timeout();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=still_running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
